// File: rtl/ads1292_filter_seq_if.sv
// Handshake bundle between the ADS1292 controller, the shared filter chain
// and the downstream consumer of filtered frames.
interface ads1292_filter_seq_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 24,
  parameter int STATUS_W = 24,
  parameter int WORD_W   = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [STATUS_W+NUM_CH*SAMPLE_W-1:0] i_ADS1292_DATA_OUT;
  logic                                i_ADS1292_DATA_VALID;
  logic [WORD_W-1:0]                   o_FILT_X;
  logic [CH_W-1:0]                     o_FILT_CH;
  logic                                o_FILT_X_VALID;
  logic                                i_FILT_X_READY;
  logic [WORD_W-1:0]                   i_FILT_Y;
  logic                                i_FILT_Y_VALID;
  logic                                o_FILT_Y_ACK;
  logic [NUM_CH*SAMPLE_W-1:0]          o_FILTERED_DATA;
  logic [STATUS_W-1:0]                 o_STATUS;
  logic                                o_FILTERED_DATA_VALID;
  logic                                i_FILTERED_DATA_ACK;
  logic                                o_BUSY;
  logic [7:0]                          o_DROP_CNT;
  logic                                o_TIMEOUT;

  modport master (
    input  i_ADS1292_DATA_OUT, i_ADS1292_DATA_VALID,
    output o_FILT_X, o_FILT_CH, o_FILT_X_VALID,
    input  i_FILT_X_READY, i_FILT_Y, i_FILT_Y_VALID,
    output o_FILT_Y_ACK,
    output o_FILTERED_DATA, o_STATUS, o_FILTERED_DATA_VALID,
    input  i_FILTERED_DATA_ACK,
    output o_BUSY, o_DROP_CNT, o_TIMEOUT
  );

  modport slave (
    output i_ADS1292_DATA_OUT, i_ADS1292_DATA_VALID,
    input  o_FILT_X, o_FILT_CH, o_FILT_X_VALID,
    output i_FILT_X_READY, i_FILT_Y, i_FILT_Y_VALID,
    input  o_FILT_Y_ACK,
    input  o_FILTERED_DATA, o_STATUS, o_FILTERED_DATA_VALID,
    output i_FILTERED_DATA_ACK,
    input  o_BUSY, o_DROP_CNT, o_TIMEOUT
  );
endinterface

// File: rtl/ads1292_filter_seq.sv
// Sequences ADS1292 frame channels through a shared tagged filter chain.
// Define ADS1292_FILTER_SEQ_TIMEOUT_EN to enable the chain watchdog.
module ads1292_filter_seq #(
  parameter int              NUM_CH      = 2,
  parameter int              SAMPLE_W    = 24,
  parameter int              STATUS_W    = 24,
  parameter int              WORD_W      = 32,
  parameter logic [NUM_CH-1:0] CH_MASK   = 2'b10,
  parameter int              TIMEOUT_CYC = 4096
) (
  input logic                  i_CLK,
  input logic                  i_RST,
  ads1292_filter_seq_if.master bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PAD_W = WORD_W - SAMPLE_W;
  localparam int FR_W  = STATUS_W + NUM_CH * SAMPLE_W;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_Y, OUT} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic [SAMPLE_W-1:0] samp_q [NUM_CH];
  logic [SAMPLE_W-1:0] samp_d [NUM_CH];
  logic [SAMPLE_W-1:0] res_q  [NUM_CH];
  logic [SAMPLE_W-1:0] res_d  [NUM_CH];
  logic [STATUS_W-1:0] stat_q, stat_d;
  logic [7:0]          drop_q, drop_d;

  logic       last, filt, x_valid, xfer, y_take, tmo, dropped;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  logic [NUM_CH*SAMPLE_W-1:0] packed_res;

  assign last    = (idx_q == CH_W'(NUM_CH - 1));
  assign filt    = CH_MASK[idx_q];
  assign x_valid = (state_q == SEND) && filt;
  assign xfer    = x_valid && bus.i_FILT_X_READY;
  assign y_take  = (state_q == WAIT_Y) && bus.i_FILT_Y_VALID;
  assign dropped = bus.i_ADS1292_DATA_VALID && (state_q != IDLE);

`ifdef ADS1292_FILTER_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;

  assign run = x_valid || (state_q == WAIT_Y);
  // A returning result or accepted sample always beats the watchdog
  assign tmo = run && (cnt_q == CNT_W'(TIMEOUT_CYC)) && !xfer && !y_take;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || xfer || y_take) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    samp_d  = samp_q;
    res_d   = res_q;
    stat_d  = stat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_ADS1292_DATA_VALID) begin
          for (int k = 0; k < NUM_CH; k++) begin
            samp_d[k] =
              bus.i_ADS1292_DATA_OUT[(NUM_CH-k)*SAMPLE_W-1 -: SAMPLE_W];
          end
          stat_d  = bus.i_ADS1292_DATA_OUT[FR_W-1 -: STATUS_W];
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tmo) begin
          state_d = IDLE;
        end else if (!filt) begin
          res_d[idx_q] = samp_q[idx_q];
          if (last) begin
            state_d = OUT;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
        end else if (xfer) begin
          state_d = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (y_take) begin
          res_d[idx_q] = bus.i_FILT_Y[WORD_W-1 -: SAMPLE_W];
          if (last) begin
            state_d = OUT;
          end else begin
            idx_d   = idx_q + CH_W'(1);
            state_d = SEND;
          end
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (bus.i_FILTERED_DATA_ACK) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign drop_inc = {1'b0, dropped} + {1'b0, tmo};
  assign drop_sum = {1'b0, drop_q} + 9'(drop_inc);
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      stat_q  <= '0;
      drop_q  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        samp_q[k] <= '0;
        res_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stat_q  <= stat_d;
      drop_q  <= drop_d;
      samp_q  <= samp_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    packed_res = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      packed_res[(NUM_CH-k)*SAMPLE_W-1 -: SAMPLE_W] = res_q[k];
    end
  end

  assign bus.o_FILT_X       = x_valid ? {samp_q[idx_q], {PAD_W{1'b0}}} : '0;
  assign bus.o_FILT_CH      = x_valid ? idx_q : '0;
  assign bus.o_FILT_X_VALID = x_valid;
  assign bus.o_FILT_Y_ACK   = y_take;

  assign bus.o_FILTERED_DATA       = packed_res;
  assign bus.o_STATUS              = stat_q;
  assign bus.o_FILTERED_DATA_VALID = (state_q == OUT);
  assign bus.o_BUSY                = (state_q != IDLE);
  assign bus.o_DROP_CNT            = drop_q;
  assign bus.o_TIMEOUT             = tmo;
endmodule

// File: tb/tb_ads1292_filter_seq.sv
// Directed bench: filtered vs bypass frames, chain stall, drops, reset.
module tb_ads1292_filter_seq;
  localparam int NCH  = 2;
  localparam int SW   = 24;
  localparam int STW  = 24;
  localparam int WW   = 32;
  localparam int TCYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [STW+NCH*SW-1:0] frame;
  logic                  dv, ready, ack_a, ack_b, chain_en, yv;
  logic [WW-1:0]         y_word;
  int n_chk = 0;
  int n_err = 0;
  int n_ack = 0;
  int n_xvb = 0;
  int n_tmo = 0;

  ads1292_filter_seq_if #(.NUM_CH(NCH), .SAMPLE_W(SW),
    .STATUS_W(STW), .WORD_W(WW)) ba ();
  ads1292_filter_seq_if #(.NUM_CH(NCH), .SAMPLE_W(SW),
    .STATUS_W(STW), .WORD_W(WW)) bb ();

  ads1292_filter_seq #(.NUM_CH(NCH), .SAMPLE_W(SW), .STATUS_W(STW),
    .WORD_W(WW), .CH_MASK(2'b10), .TIMEOUT_CYC(TCYC))
    dut (.i_CLK(clk), .i_RST(rst), .bus(ba.master));

  ads1292_filter_seq #(.NUM_CH(NCH), .SAMPLE_W(SW), .STATUS_W(STW),
    .WORD_W(WW), .CH_MASK(2'b00), .TIMEOUT_CYC(TCYC))
    dut_b (.i_CLK(clk), .i_RST(rst), .bus(bb.master));

  assign ba.i_ADS1292_DATA_OUT   = frame;
  assign ba.i_ADS1292_DATA_VALID = dv;
  assign ba.i_FILT_X_READY       = ready;
  assign ba.i_FILT_Y             = y_word;
  assign ba.i_FILT_Y_VALID       = yv;
  assign ba.i_FILTERED_DATA_ACK  = ack_a;

  assign bb.i_ADS1292_DATA_OUT   = frame;
  assign bb.i_ADS1292_DATA_VALID = dv;
  assign bb.i_FILT_X_READY       = ready;
  assign bb.i_FILT_Y             = '0;
  assign bb.i_FILT_Y_VALID       = 1'b0;
  assign bb.i_FILTERED_DATA_ACK  = ack_b;

  // chain model: result is valid the cycle after accept, held until acked
  always @(posedge clk or posedge rst) begin
    if (rst) yv <= 1'b0;
    else if (ba.o_FILT_X_VALID && ready && chain_en) yv <= 1'b1;
    else if (ba.o_FILT_Y_ACK) yv <= 1'b0;
  end

  always @(posedge clk) begin
    if (ba.o_FILT_Y_ACK)   n_ack <= n_ack + 1;
    if (bb.o_FILT_X_VALID) n_xvb <= n_xvb + 1;
    if (ba.o_TIMEOUT)      n_tmo <= n_tmo + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [23:0] st, input logic [23:0] c0,
                      input logic [23:0] c1);
    @(negedge clk);
    frame = {st, c0, c1};
    dv    = 1'b1;
    @(negedge clk);
    dv    = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int i;
    i = 0;
    while (!ba.o_FILTERED_DATA_VALID && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(ba.o_FILTERED_DATA_VALID), 64'd1);
  endtask

  task automatic ack_out();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
  endtask

  initial begin
    int bad;
    int acks0;
    int i;
    frame    = '0;
    dv       = 1'b0;
    ready    = 1'b1;
    ack_a    = 1'b0;
    ack_b    = 1'b0;
    chain_en = 1'b1;
    y_word   = 32'h00ABCD12;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(ba.o_FILTERED_DATA_VALID), 64'd0);
    chk("rst_busy", 64'(ba.o_BUSY), 64'd0);
    chk("rst_drop", 64'(ba.o_DROP_CNT), 64'd0);
    chk("rst_data", 64'(ba.o_FILTERED_DATA), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic frame: ch1 filtered on dut, all-bypass on dut_b
    send(24'hC00000, 24'h123456, 24'hFFF000);
    chk("b_valid_n0", 64'(bb.o_FILTERED_DATA_VALID), 64'd0);
    @(negedge clk);
    chk("x_valid", 64'(ba.o_FILT_X_VALID), 64'd1);
    chk("x_data", 64'(ba.o_FILT_X), 64'hFFF00000);
    chk("x_ch", 64'(ba.o_FILT_CH), 64'd1);
    chk("b_valid_n1", 64'(bb.o_FILTERED_DATA_VALID), 64'd0);
    @(negedge clk);
    chk("b_valid_n2", 64'(bb.o_FILTERED_DATA_VALID), 64'd1);
    chk("b_data", 64'(bb.o_FILTERED_DATA), 64'h123456FFF000);
    chk("b_status", 64'(bb.o_STATUS), 64'hC00000);
    chk("y_ack", 64'(ba.o_FILT_Y_ACK), 64'd1);
    @(negedge clk);
    wait_out("out_valid1");
    chk("out_data1", 64'(ba.o_FILTERED_DATA), 64'h12345600ABCD);
    chk("out_status1", 64'(ba.o_STATUS), 64'hC00000);
    chk("ack_count1", 64'(n_ack), 64'd1);
    chk("b_no_xvalid", 64'(n_xvb), 64'd0);
    ack_b = 1'b1;
    ack_out();
    ack_b = 1'b0;
    chk("idle_after_ack", 64'(ba.o_BUSY), 64'd0);

    // chain back-pressure for 20 cycles
    ready = 1'b0;
    send(24'hC00000, 24'h123456, 24'hFFF000);
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (!(ba.o_FILT_X_VALID && ba.o_FILT_X == 32'hFFF00000 &&
            ba.o_FILT_CH == 1'b1)) bad++;
      @(negedge clk);
    end
    chk("stall_stable", 64'(bad), 64'd0);
    ready = 1'b1;
    @(negedge clk);
    chk("stall_xv_drop", 64'(ba.o_FILT_X_VALID), 64'd0);
    chk("stall_y_ack", 64'(ba.o_FILT_Y_ACK), 64'd1);
    @(negedge clk);
    wait_out("out_valid2");
    chk("out_data2", 64'(ba.o_FILTERED_DATA), 64'h12345600ABCD);

    // output held while frames arrive and are dropped
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      frame = {24'h111111, 24'h000001, 24'h000002};
      dv    = (k == 1 || k == 4 || k == 7);
    end
    @(negedge clk);
    dv = 1'b0;
    chk("hold_valid", 64'(ba.o_FILTERED_DATA_VALID), 64'd1);
    chk("hold_data", 64'(ba.o_FILTERED_DATA), 64'h12345600ABCD);
    chk("drop3", 64'(ba.o_DROP_CNT), 64'd3);
    dv = 1'b1;
    ack_out();
    dv = 1'b0;
    chk("drop_on_ack_edge", 64'(ba.o_DROP_CNT), 64'd4);
    chk("idle_after_drop", 64'(ba.o_BUSY), 64'd0);
    y_word = 32'h80000001;
    send(24'h0A0A0A, 24'h7FFFFF, 24'h800000);
    @(negedge clk);
    chk("x_data_neg", 64'(ba.o_FILT_X), 64'h80000000);
    wait_out("out_valid3");
    chk("out_data3", 64'(ba.o_FILTERED_DATA), 64'h7FFFFF800000);
    chk("out_status3", 64'(ba.o_STATUS), 64'h0A0A0A);
    chk("drop_kept", 64'(ba.o_DROP_CNT), 64'd4);
    ack_out();

    // reset while waiting for a chain result
    chain_en = 1'b0;
    acks0    = n_ack;
    send(24'hC00000, 24'h123456, 24'hFFF000);
    repeat (3) @(negedge clk);
    chk("wy_busy", 64'(ba.o_BUSY), 64'd1);
    chk("wy_xvalid", 64'(ba.o_FILT_X_VALID), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(ba.o_BUSY), 64'd0);
    chk("mid_rst_drop", 64'(ba.o_DROP_CNT), 64'd0);
    chk("mid_rst_data", 64'(ba.o_FILTERED_DATA), 64'd0);
    chk("mid_rst_status", 64'(ba.o_STATUS), 64'd0);
    chk("mid_rst_ack", 64'(ba.o_FILT_Y_ACK), 64'd0);
    chk("mid_rst_xv", 64'(ba.o_FILT_X_VALID), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    chain_en = 1'b1;
    y_word   = 32'h00ABCD12;
    send(24'hC00000, 24'h123456, 24'hFFF000);
    wait_out("out_valid4");
    chk("out_data4", 64'(ba.o_FILTERED_DATA), 64'h12345600ABCD);
    chk("ack_after_rst", 64'(n_ack - acks0), 64'd1);
    ack_out();

    // chain never answers
    chain_en = 1'b0;
    send(24'hC00000, 24'h123456, 24'hFFF000);
    @(negedge clk);
`ifdef ADS1292_FILTER_SEQ_TIMEOUT_EN
    i = 0;
    while (!ba.o_TIMEOUT && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("tmo_latency", 64'(i), 64'd17);
    chk("tmo_no_ack", 64'(ba.o_FILT_Y_ACK), 64'd0);
    @(negedge clk);
    chk("tmo_idle", 64'(ba.o_BUSY), 64'd0);
    chk("tmo_drop", 64'(ba.o_DROP_CNT), 64'd1);
    chk("tmo_pulses", 64'(n_tmo), 64'd1);
    chk("tmo_no_frame", 64'(ba.o_FILTERED_DATA_VALID), 64'd0);
`else
    i = 0;
    repeat (40) @(negedge clk);
    chk("wait_forever_busy", 64'(ba.o_BUSY), 64'd1);
    chk("no_tmo", 64'(n_tmo + i), 64'd0);
    chk("no_drop", 64'(ba.o_DROP_CNT), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
